// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment/anode constants and scan phase type for the 7-segment scan driver
package seg7_pkg;
  localparam int NDIGITS = 8;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [7:0] AN_OFF   = 8'hFF;
  typedef enum logic {PH_BLANK, PH_ON} phase_t;
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: digit word/cursor/point inputs and multiplexed display outputs
interface seg7_scan_driver_if;
  import seg7_pkg::*;
  logic [31:0]         data_i;
  logic [2:0]          cur_i;
  logic [NDIGITS-1:0]  dp_i;
  logic [NDIGITS-1:0]  an_o;
  logic [6:0]          seg_o;
  logic                dp_o;
  modport master (output data_i, cur_i, dp_i, input an_o, seg_o, dp_o);
  modport slave (input data_i, cur_i, dp_i, output an_o, seg_o, dp_o);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit BCD to active-low {g,f,e,d,c,b,a}, dash for non-BCD codes
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  // Plain lookup; codes 10..15 show a dash so corrupt digits are visible
  always_comb begin
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed common-anode scan with per-frame snapshot; SEG7_SCAN_BLINK_EN adds cursor blink
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter int BLINK_CYCLES = 25000000
) (
  input logic clk,
  input logic rst,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [NDIGITS-1:0] dp_shadow_q, dp_shadow_d;
  logic [NDIGITS-1:0] an_q, an_d;
  logic [6:0]         seg_q, seg_d, dec;
  logic               dp_q, dp_d;
  logic               wrap, hide;
  phase_t             phase;
`ifdef SEG7_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES);
  logic [BW-1:0] blink_q;
  logic          hidden_q;
  logic          blink_wrap;
  assign blink_wrap = blink_q == BW'(BLINK_CYCLES - 1);
  // Blink half-period timer; phase flips each time it wraps, starting visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q  <= '0;
      hidden_q <= 1'b0;
    end else begin
      blink_q  <= blink_wrap ? '0 : blink_q + 1'b1;
      hidden_q <= hidden_q ^ blink_wrap;
    end
  end
  assign hide = hidden_q && idx_q == bus.cur_i;
`else
  logic unused_blink;
  assign unused_blink = ^bus.cur_i ^ (BLINK_CYCLES > 0);
  assign hide = 1'b0;
`endif
  seg7_decode u_dec (.bcd_i(shadow_q[{idx_q, 2'b00} +: 4]), .seg_o(dec));
  // Next scan position, end-of-frame snapshot and the registered output image
  always_comb begin
    wrap        = cnt_q == CW'(DIGIT_CYCLES - 1);
    cnt_d       = wrap ? '0 : cnt_q + 1'b1;
    idx_d       = wrap ? idx_q + 3'd1 : idx_q;
    shadow_d    = (wrap && idx_q == 3'(NDIGITS - 1)) ? bus.data_i : shadow_q;
    dp_shadow_d = (wrap && idx_q == 3'(NDIGITS - 1)) ? bus.dp_i : dp_shadow_q;
    phase       = (cnt_q < CW'(BLANK_CYCLES) || hide) ? PH_BLANK : PH_ON;
    an_d        = phase == PH_BLANK ? AN_OFF : ~(8'd1 << idx_q);
    seg_d       = phase == PH_BLANK ? SEG_OFF : dec;
    dp_d        = phase == PH_BLANK ? 1'b1 : ~dp_shadow_q[idx_q];
  end
  // All scan state and outputs; reset blanks the display at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      dp_shadow_q <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      dp_shadow_q <= dp_shadow_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end
  assign bus.an_o  = an_q;
  assign bus.seg_o = seg_q;
  assign bus.dp_o  = dp_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: random and directed scan checks against a time-based display model
module tb_seg7_scan_driver;
  localparam int D  = 8;
  localparam int B  = 2;
  localparam int BL = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int t = 0;
  logic [31:0] m_sh;
  logic [7:0]  m_dp;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [6:0]  glyph [16];
  seg7_scan_driver_if bus ();
  seg7_scan_driver #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B), .BLINK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
              7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
  end
  // Model: t clocks after reset the display is showing scan slot t-1 of the frame snapshot
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; m_sh = 0; m_dp = 0; e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      automatic int c = t % D;
      automatic int k = (t / D) % 8;
      automatic bit hid = 1'b0;
`ifdef SEG7_SCAN_BLINK_EN
      hid = ((t / BL) % 2 == 1) && (k == int'(bus.cur_i));
`endif
      if (c < B || hid) begin
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an = 8'hFF ^ (8'd1 << k); e_seg = glyph[m_sh[4*k +: 4]]; e_dp = !m_dp[k];
      end
      if (c == D - 1 && k == 7) begin
        m_sh = bus.data_i; m_dp = bus.dp_i;
      end
      t++;
    end
  end
  task automatic chk(input string tag);
    checks++;
    assert (bus.an_o === e_an) else begin errors++; $error("FAIL %s an_o got %h exp %h t=%0d", tag, bus.an_o, e_an, t); end
    checks++;
    assert (bus.seg_o === e_seg) else begin errors++; $error("FAIL %s seg_o got %b exp %b t=%0d", tag, bus.seg_o, e_seg, t); end
    checks++;
    assert (bus.dp_o === e_dp) else begin errors++; $error("FAIL %s dp_o got %b exp %b t=%0d", tag, bus.dp_o, e_dp, t); end
  endtask
  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      chk(tag);
    end
  endtask
  task automatic seek(input int k, input int c);
    for (int i = 0; i < 8 * D && !((t / D) % 8 == k && t % D == c); i++) run(1, "seek");
  endtask
  initial begin
    bus.data_i = 32'h87654321; bus.dp_i = 8'h00; bus.cur_i = 3'd5;
    repeat (3) @(negedge clk);
    chk("reset");
    rst = 1'b0;
    run(B, "post_rst_blank");
    @(negedge clk);
    chk("first_on");
    checks++;
    assert (bus.an_o === 8'hFE && bus.seg_o === 7'b1000000) else begin
      errors++; $error("FAIL first_on an/seg got %h/%b exp fe/1000000", bus.an_o, bus.seg_o);
    end
    run(2 * 8 * D, "frames_87654321");
    bus.data_i = 32'h11111111;
    run(8 * D, "ones");
    seek(3, 0);
    bus.data_i = 32'h22222222;
    run(2 * 8 * D, "mid_frame_change");
    bus.data_i = 32'hFEDCBA90;
    run(2 * 8 * D, "dash");
    bus.dp_i = 8'h04;
    run(2 * 8 * D, "dp");
    for (int i = 0; i < 8; i++) begin
      bus.data_i = $urandom; bus.dp_i = 8'($urandom); bus.cur_i = 3'($urandom_range(7));
      run($urandom_range(20, 150), "random");
    end
    bus.cur_i = 3'd5;
    bus.data_i = 32'h55555555;
    run(4 * BL, "blink");
    seek(6, 4);
    #2 rst = 1'b1;
    #1;
    checks++;
    assert (bus.an_o === 8'hFF && bus.seg_o === 7'h7F && bus.dp_o === 1'b1) else begin
      errors++; $error("FAIL async_rst got %h/%b/%b exp ff/1111111/1", bus.an_o, bus.seg_o, bus.dp_o);
    end
    @(negedge clk);
    chk("in_reset");
    rst = 1'b0;
    run(8 * D + 4, "restart");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
